// File: rtl/audio_pdm_dac_pkg.sv
// audio_pdm_dac_pkg: shared constants and helpers for the SID audio PDM DAC
package audio_pdm_dac_pkg;
   localparam int IN_W_DEF   = 12;
   localparam int ACC_W_DEF  = 18;
   localparam int GAIN_W     = 9;
   localparam int GAIN_UNITY = 256;
   localparam logic signed [12:0] FB_POS = 13'sd2047;
   localparam logic signed [12:0] FB_NEG = -13'sd2048;

   function automatic longint acc_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint acc_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   localparam longint ACC_MAX = acc_max(ACC_W_DEF);
   localparam longint ACC_MIN = acc_min(ACC_W_DEF);
endpackage

// File: rtl/audio_gain_ramp.sv
// audio_gain_ramp: click-free gain ramp and amplifier enable sequencing
module audio_gain_ramp
   import audio_pdm_dac_pkg::*;
#(
   parameter int RAMP_DIV = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable_i,
   input  logic              mute_i,
   output logic [GAIN_W-1:0] gain_o,
   output logic              amp_en_o
);
   localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [CW-1:0]     cnt;
   logic              wrap;
   logic [GAIN_W-1:0] target;
   logic [GAIN_W-1:0] gain_n;
   logic              amp_n;

   // step gain one unit toward target on each counter wrap; amp drops only once silent
   always_comb begin
      wrap   = (cnt == CW'(RAMP_DIV - 1));
      target = (enable_i & ~mute_i) ? GAIN_W'(GAIN_UNITY) : '0;
      gain_n = (!wrap || gain_o == target) ? gain_o :
               (gain_o < target) ? gain_o + 1'b1 : gain_o - 1'b1;
      amp_n  = enable_i ? 1'b1 : (gain_o == '0) ? 1'b0 : amp_en_o;
   end

   // ramp counter, gain and amplifier enable registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         gain_o   <= '0;
         amp_en_o <= 1'b0;
      end else begin
         cnt      <= wrap ? '0 : cnt + 1'b1;
         gain_o   <= gain_n;
         amp_en_o <= amp_n;
      end
   end
endmodule

// File: rtl/audio_pdm_dac.sv
// audio_pdm_dac: second-order delta-sigma PDM DAC for the 12-bit SID audio bus
module audio_pdm_dac
   import audio_pdm_dac_pkg::*;
#(
   parameter int IN_W     = IN_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int RAMP_DIV = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [IN_W-1:0]   sample_i,
   input  logic              sample_valid_i,
   input  logic              enable_i,
   input  logic              mute_i,
   input  logic              clip_clr_i,
   output logic              pdm_o,
   output logic              amp_en_o,
   output logic              clip_o,
   output logic [GAIN_W-1:0] gain_o
);
   // one guard bit beyond ACC_W+1 keeps three-term sums exact even at narrow ACC_W
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] SMAX = SW'(acc_max(ACC_W));
   localparam logic signed [SW-1:0] SMIN = SW'(acc_min(ACC_W));

   logic [IN_W-1:0]             hold;
   logic signed [IN_W-1:0]      s;
   logic signed [IN_W+GAIN_W:0] prod;
   logic signed [IN_W:0]        x, x_n;
   logic signed [SW-1:0]        fb, a1, a2;
   logic signed [ACC_W-1:0]     i1, i2, i1_n, i2_n;
   logic                        c1, c2, pdm_n, clip_n;

   audio_gain_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable_i (enable_i),
      .mute_i   (mute_i),
      .gain_o   (gain_o),
      .amp_en_o (amp_en_o)
   );

   // offset-binary to signed, gain scaling, and both saturating integrator updates
   always_comb begin
      s      = {~hold[IN_W-1], hold[IN_W-2:0]};
      prod   = s * $signed({1'b0, gain_o});
      x_n    = (IN_W + 1)'(prod >>> 8);
      fb     = pdm_o ? SW'(FB_POS) : SW'(FB_NEG);
      a1     = SW'(i1) + SW'(x) - fb;
      c1     = (a1 > SMAX) || (a1 < SMIN);
      i1_n   = (a1 > SMAX) ? ACC_W'(SMAX) : (a1 < SMIN) ? ACC_W'(SMIN) : ACC_W'(a1);
      a2     = SW'(i2) + SW'(i1_n) - fb;
      c2     = (a2 > SMAX) || (a2 < SMIN);
      i2_n   = (a2 > SMAX) ? ACC_W'(SMAX) : (a2 < SMIN) ? ACC_W'(SMIN) : ACC_W'(a2);
      pdm_n  = ~i2_n[ACC_W-1];
      clip_n = c1 | c2 | (clip_o & ~clip_clr_i);
   end

   // sample hold, scaled-sample pipeline register and modulator state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold   <= IN_W'(1 << (IN_W - 1));
         x      <= '0;
         i1     <= '0;
         i2     <= '0;
         pdm_o  <= 1'b0;
         clip_o <= 1'b0;
      end else begin
         hold   <= sample_valid_i ? sample_i : hold;
         x      <= x_n;
         i1     <= i1_n;
         i2     <= i2_n;
         pdm_o  <= pdm_n;
         clip_o <= clip_n;
      end
   end
endmodule

// File: tb/tb_audio_pdm_dac.sv
// tb_audio_pdm_dac: directed self-checking bench for audio_pdm_dac
module tb_audio_pdm_dac;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] sample_i = 12'd2048;
   logic        sample_valid_i = 1'b0;
   logic        enable_i = 1'b0;
   logic        mute_i = 1'b0;
   logic        clip_clr_i = 1'b0;
   logic        pdm, amp_en, clip;
   logic [8:0]  gain;
   logic        pdm12, amp_en12, clip12;
   logic [8:0]  gain12;
   int          checks = 0;
   int          failures = 0;
   int          ones;

   always #5 clk = ~clk;

   audio_pdm_dac #(.IN_W(12), .ACC_W(18), .RAMP_DIV(4)) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .enable_i       (enable_i),
      .mute_i         (mute_i),
      .clip_clr_i     (clip_clr_i),
      .pdm_o          (pdm),
      .amp_en_o       (amp_en),
      .clip_o         (clip),
      .gain_o         (gain)
   );

   audio_pdm_dac #(.IN_W(12), .ACC_W(12), .RAMP_DIV(4)) u_dut12 (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .enable_i       (enable_i),
      .mute_i         (mute_i),
      .clip_clr_i     (clip_clr_i),
      .pdm_o          (pdm12),
      .amp_en_o       (amp_en12),
      .clip_o         (clip12),
      .gain_o         (gain12)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic count_ones(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         cnt += int'(pdm);
      end
   endtask

   task automatic push(input int v);
      sample_i = 12'(v);
      sample_valid_i = 1'b1;
      step(1);
      sample_valid_i = 1'b0;
   endtask

   task automatic wait_gain(input string tag, input int tgt, input int budget);
      int k = 0;
      while (int'(gain) != tgt && k < budget) begin
         step(1);
         k++;
      end
      chk(tag, int'(gain), tgt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gain", int'(gain), 0);
      chk("rst_pdm", int'(pdm), 0);
      chk("rst_amp", int'(amp_en), 0);
      chk("rst_clip", int'(clip), 0);
      enable_i = 1'b1;
      clip_clr_i = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      step(1);
      chk("e1_pdm", int'(pdm), 1);
      chk("e1_pdm12", int'(pdm12), 1);
      chk("e1_clip12_wins", int'(clip12), 1);
      chk("e1_clip18", int'(clip), 0);
      chk("e1_amp", int'(amp_en), 1);
      step(1);
      chk("e2_pdm", int'(pdm), 1);
      chk("e2_clip12_clr", int'(clip12), 0);
      step(1);
      chk("e3_pdm", int'(pdm), 0);
      chk("e3_pdm12", int'(pdm12), 0);
      chk("e3_clip12", int'(clip12), 1);
      chk("e3_gain", int'(gain), 0);
      clip_clr_i = 1'b0;
      step(1020);
      chk("up_1023", int'(gain), 255);
      step(1);
      chk("up_1024", int'(gain), 256);
      count_ones(4096, ones);
      chk("dens_mid", int'(ones >= 2028 && ones <= 2068), 1);
      chk("mid_clip", int'(clip), 0);
      push(3071);
      step(64);
      count_ones(8192, ones);
      chk("dens_75", int'(ones >= 6102 && ones <= 6185), 1);
      chk("q_clip", int'(clip), 0);
      push(4095);
      step(256);
      count_ones(2048, ones);
      chk("dens_full", int'(ones >= 2028), 1);
      push(0);
      step(256);
      count_ones(2048, ones);
      chk("dens_zero", int'(ones <= 20), 1);
      push(2048);
      step(2048);
      enable_i = 1'b0;
      wait_gain("dn_255", 255, 8);
      step(4);
      chk("dn_254", int'(gain), 254);
      chk("dn_amp", int'(amp_en), 1);
      step(504);
      chk("dn_128", int'(gain), 128);
      chk("dn_128_amp", int'(amp_en), 1);
      enable_i = 1'b1;
      step(4);
      chk("rev_129", int'(gain), 129);
      chk("rev_amp", int'(amp_en), 1);
      step(508);
      chk("rev_256", int'(gain), 256);
      mute_i = 1'b1;
      step(1020);
      chk("mute_1", int'(gain), 1);
      step(4);
      chk("mute_0", int'(gain), 0);
      step(2);
      chk("mute_hold0", int'(gain), 0);
      chk("mute_amp", int'(amp_en), 1);
      mute_i = 1'b0;
      step(2);
      chk("unmute_1", int'(gain), 1);
      step(1020);
      chk("unmute_256", int'(gain), 256);
      enable_i = 1'b0;
      step(1020);
      chk("off_1", int'(gain), 1);
      chk("off_1_amp", int'(amp_en), 1);
      step(4);
      chk("off_0", int'(gain), 0);
      chk("off_0_amp", int'(amp_en), 1);
      step(1);
      chk("off_amp_drop", int'(amp_en), 0);
      step(7);
      chk("off_no_overshoot", int'(gain), 0);
      enable_i = 1'b1;
      step(1);
      chk("on_amp", int'(amp_en), 1);
      wait_gain("on_100", 100, 1000);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_gain", int'(gain), 0);
      chk("arst_pdm", int'(pdm), 0);
      chk("arst_amp", int'(amp_en), 0);
      chk("arst_clip", int'(clip), 0);
      chk("arst_clip12", int'(clip12), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
